trb_in_sched: RTL and testbench
===============================

// Module: trb_in_sched
// PURPOSE
// - Frame-level scheduler on the input side of the NUM_TURBO turbo decoder array.
// - Takes one upstream Avalon-ST byte stream of fixed-length frames.
// - Routes each whole frame to one decoder core, chosen round-robin among cores that are ready and below their outstanding-frame limit.
// - Counts frames in flight per core (dispatched minus completed) so no core is overloaded.
// PARAMETERS
// NUM_TURBO   2     number of decoder cores (1..16)
// DATA_W      8     stream data width
// FRAME_LEN   128   beats per frame (turbo_length/8); power of two not required
// MAX_OUT     4     max frames in flight per core (1..15)
// PORTS
// clk            in   1           clock
// rst_n          in   1           asynchronous active-low reset
// st_data_in     in   DATA_W      upstream data
// st_valid_in    in   1           upstream valid
// st_sop_in      in   1           upstream start of frame (checked only)
// st_eop_in      in   1           upstream end of frame (checked only)
// st_ready_out   out  1           upstream ready
// dec_data_out   out  DATA_W      data broadcast to all cores
// dec_valid_out  out  NUM_TURBO   per-core valid (one-hot or zero)
// dec_sop_out    out  NUM_TURBO   per-core sop, generated from beat count
// dec_eop_out    out  NUM_TURBO   per-core eop, generated from beat count
// dec_ready_in   in   NUM_TURBO   per-core ready
// dec_done_in    in   NUM_TURBO   1-clk pulse per frame finished by core
// cur_core       out  4           granted core index (valid in XFER)
// err_len        out  1           sticky: sop/eop position mismatch
// err_credit     out  NUM_TURBO   sticky: done pulse with zero in flight
// BEHAVIOUR
// - Reset: async on rst_n low; all state cleared; FSM=IDLE; ptr=0; credits=0; beat=0.
//   All outputs 0. A frame cut by reset is abandoned; the core sees no eop.
// - FSM:
//   - IDLE: go to ARB when st_valid_in=1.
//   - ARB: one-cycle search from ptr upward with wrap, over cores with dec_ready_in=1 and credit<MAX_OUT.
//     If one is found, latch grant g (cur_core<=g) and go to XFER. If none is found, stay in ARB and retry each clk.
//   - XFER: stay until the FRAME_LEN-th beat is accepted, then go to IDLE.
// - Passthrough in XFER (combinational, zero latency):
//   - st_ready_out = dec_ready_in[g]
//   - dec_valid_out[g] = st_valid_in
//   - dec_data_out = st_data_in
//   - All other cores' valid = 0.
// - Outside XFER: st_ready_out=0 and dec_valid_out=0.
// - First beat is accepted no earlier than 2 clks after st_valid_in rises in IDLE.
// - Beat accepted = st_valid_in & st_ready_out. beat counts 0..FRAME_LEN-1 and resets to 0 after the last beat.
// - dec_sop_out[g] = valid & (beat==0); dec_eop_out[g] = valid & (beat==FRAME_LEN-1).
// - err_len is set (sticky until reset) on an accepted beat where:
//   - st_sop_in != (beat==0), or
//   - st_eop_in != (beat==FRAME_LEN-1).
//   Forwarding continues unchanged.
// - On the last accepted beat: credit[g]+=1 and ptr = (g==NUM_TURBO-1) ? 0 : g+1.
// - dec_done_in[k]: credit[k]-=1 if credit[k]>0. If credit[k]==0, credit stays 0 and err_credit[k] is set (sticky).
// - Dispatch end and done on the same core in the same clk: credit unchanged.
// - Done on multiple cores in the same clk: each core is handled independently.
// - A core whose credit==MAX_OUT is skipped by ARB until a done pulse arrives.
// - dec_ready_in[g] dropping mid-frame stalls the transfer; the grant is held and never switched mid-frame.
// - NUM_TURBO==1: ptr stays 0; all other rules are unchanged.
// TESTING
// - NUM_TURBO=2, both ready, 3 back-to-back frames -> frames go to cores 0,1,0; each shows 128 valid beats, sop on beat 0, eop on beat 127.
// - Core0 ready=0 during ARB, core1 ready -> grant core1, cur_core=1; next frame searches from ptr=0 and goes to core0 once it is ready.
// - MAX_OUT=4, no done pulses, 9 frames -> 4 to each core; 9th held in ARB with st_ready_out=0; one done on core0 -> 9th goes to core0.
// - dec_ready_in[g]=0 for 5 clks at beat 60 -> st_ready_out=0 for those 5 clks; no beat lost or duplicated; eop still at beat 127.
// - Upstream eop at beat 100 -> err_len=1 stays high; core still receives 128 beats with eop at beat 127.
// - dec_done_in[1] pulse with credit[1]=0 -> err_credit[1]=1, credit[1] stays 0. rst_n low mid-frame -> all outputs 0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/trb_in_sched.sv
// trb_in_sched: round-robin frame scheduler in front of NUM_TURBO turbo decoder cores.
// Rev 1.0 - initial release.
`default_nettype none

module trb_in_sched #(
  parameter int NUM_TURBO = 2,
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 128,
  parameter int MAX_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    st_data_in,
  input  logic                 st_valid_in,
  input  logic                 st_sop_in,
  input  logic                 st_eop_in,
  output logic                 st_ready_out,
  output logic [DATA_W-1:0]    dec_data_out,
  output logic [NUM_TURBO-1:0] dec_valid_out,
  output logic [NUM_TURBO-1:0] dec_sop_out,
  output logic [NUM_TURBO-1:0] dec_eop_out,
  input  logic [NUM_TURBO-1:0] dec_ready_in,
  input  logic [NUM_TURBO-1:0] dec_done_in,
  output logic [3:0]           cur_core,
  output logic                 err_len,
  output logic [NUM_TURBO-1:0] err_credit
);

  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2
  } state_e;

  state_e               state_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [3:0]           ptr_q;
  logic [3:0]           cur_core_q;
  logic [NUM_TURBO-1:0] gnt_q;
  logic                 err_len_q;
  logic [NUM_TURBO-1:0] err_credit_q;
  logic [NUM_TURBO-1:0] err_credit_d;
  logic [3:0]           credit_q [NUM_TURBO];
  logic [3:0]           credit_d [NUM_TURBO];

  logic                 xfer;
  logic                 accept;
  logic                 first_beat;
  logic                 last_beat;
  logic [NUM_TURBO-1:0] dispatch;
  logic [15:0]          elig;
  logic                 found;
  logic [3:0]           sel;
  logic [4:0]           idx;

  assign xfer         = (state_q == S_XFER);
  assign st_ready_out = xfer & (|(dec_ready_in & gnt_q));
  assign accept       = st_valid_in & st_ready_out;
  assign first_beat   = (beat_q == '0);
  assign last_beat    = (beat_q == LAST_BEAT);

  // Data is zeroed outside a transfer so every output reads 0 while idle/in reset.
  assign dec_data_out  = xfer ? st_data_in : '0;
  assign dec_valid_out = (xfer & st_valid_in) ? gnt_q : '0;
  assign dec_sop_out   = first_beat ? dec_valid_out : '0;
  assign dec_eop_out   = last_beat  ? dec_valid_out : '0;
  assign dispatch      = (accept & last_beat) ? gnt_q : '0;

  assign cur_core   = cur_core_q;
  assign err_len    = err_len_q;
  assign err_credit = err_credit_q;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_TURBO; k++) begin
      elig[k] = dec_ready_in[k] & (credit_q[k] < 4'(MAX_OUT));
    end
  end

  // Rotating search: first eligible core at or above ptr, wrapping at NUM_TURBO.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_TURBO; i++) begin
      idx = {1'b0, ptr_q} + 5'(i);
      if (idx >= 5'(NUM_TURBO)) idx = idx - 5'(NUM_TURBO);
      if (!found && elig[idx[3:0]]) begin
        found = 1'b1;
        sel   = idx[3:0];
      end
    end
  end

  always_comb begin
    err_credit_d = err_credit_q;
    for (int k = 0; k < NUM_TURBO; k++) begin
      credit_d[k] = credit_q[k];
      if (dispatch[k] && !dec_done_in[k]) begin
        credit_d[k] = credit_q[k] + 4'd1;
      end else if (!dispatch[k] && dec_done_in[k]) begin
        if (credit_q[k] != 4'd0) credit_d[k] = credit_q[k] - 4'd1;
        else                     err_credit_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      ptr_q        <= '0;
      cur_core_q   <= '0;
      gnt_q        <= '0;
      err_len_q    <= 1'b0;
      err_credit_q <= '0;
      for (int k = 0; k < NUM_TURBO; k++) credit_q[k] <= '0;
    end else begin
      err_credit_q <= err_credit_d;
      for (int k = 0; k < NUM_TURBO; k++) credit_q[k] <= credit_d[k];
      if (accept && ((st_sop_in != first_beat) || (st_eop_in != last_beat))) begin
        err_len_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (st_valid_in) state_q <= S_ARB;
        end
        S_ARB: begin
          if (found) begin
            cur_core_q <= sel;
            for (int k = 0; k < NUM_TURBO; k++) gnt_q[k] <= (sel == 4'(k));
            state_q    <= S_XFER;
          end
        end
        S_XFER: begin
          if (accept) begin
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= S_IDLE;
              ptr_q   <= (cur_core_q == 4'(NUM_TURBO - 1)) ? 4'd0 : cur_core_q + 4'd1;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trb_in_sched.sv
// tb_trb_in_sched: directed self-checking bench for trb_in_sched (2 cores, 128-beat frames).
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_trb_in_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] st_data = '0;
  logic       st_valid = 1'b0;
  logic       st_sop = 1'b0;
  logic       st_eop = 1'b0;
  logic       st_ready_out;
  logic [7:0] dec_data_out;
  logic [1:0] dec_valid_out, dec_sop_out, dec_eop_out;
  logic [1:0] dec_ready = 2'b00;
  logic [1:0] dec_done = 2'b00;
  logic [3:0] cur_core;
  logic       err_len;
  logic [1:0] err_credit;

  int errors = 0;
  int checks = 0;
  int frame_core[$];
  int mon_beat[2] = '{0, 0};
  int bad_sop = 0, bad_eop = 0, bad_data = 0, bad_oh = 0;
  int last_cur = -1;
  int tmo_cnt = 0;
  int stall_cyc = 0, stall_bad = 0;

  trb_in_sched #(.NUM_TURBO(2), .DATA_W(8), .FRAME_LEN(128), .MAX_OUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_data_in   (st_data),
    .st_valid_in  (st_valid),
    .st_sop_in    (st_sop),
    .st_eop_in    (st_eop),
    .st_ready_out (st_ready_out),
    .dec_data_out (dec_data_out),
    .dec_valid_out(dec_valid_out),
    .dec_sop_out  (dec_sop_out),
    .dec_eop_out  (dec_eop_out),
    .dec_ready_in (dec_ready),
    .dec_done_in  (dec_done),
    .cur_core     (cur_core),
    .err_len      (err_len),
    .err_credit   (err_credit)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Per-core receiver model: beat position, sop/eop placement, data order.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_beat[0] = 0;
      mon_beat[1] = 0;
    end else begin
      if ((dec_valid_out & (dec_valid_out - 2'd1)) != 2'b00) bad_oh++;
      for (int k = 0; k < 2; k++) begin
        if (!dec_valid_out[k] && (dec_sop_out[k] || dec_eop_out[k])) bad_sop++;
        if (dec_valid_out[k] && dec_ready[k]) begin
          if (dec_sop_out[k] !== (mon_beat[k] == 0))   bad_sop++;
          if (dec_eop_out[k] !== (mon_beat[k] == 127)) bad_eop++;
          if (dec_data_out !== 8'(mon_beat[k]))       bad_data++;
          if (mon_beat[k] == 127) begin
            frame_core.push_back(k);
            mon_beat[k] = 0;
          end else begin
            mon_beat[k]++;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_data = '0;
    dec_done = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    frame_core.delete();
  endtask

  task automatic send_frame(input int eop_at, input int stall_beat, input int stall_len);
    int b, cyc, st_left;
    bit stalled;
    logic acc;
    logic [1:0] rsave;
    b = 0; cyc = 0; st_left = 0; stalled = 0; rsave = dec_ready;
    while (b < 128 && cyc < 2000) begin
      if (!stalled && b == stall_beat) begin
        rsave = dec_ready; dec_ready = 2'b00; st_left = stall_len; stalled = 1;
      end
      st_valid = 1'b1; st_data = 8'(b); st_sop = (b == 0); st_eop = (b == eop_at);
      @(negedge clk);
      acc = st_valid & st_ready_out;
      if (acc && b == 0) last_cur = int'(cur_core);
      if (st_left > 0) begin
        stall_cyc++;
        if (st_ready_out !== 1'b0) stall_bad++;
      end
      @(posedge clk); #1;
      if (acc) b++;
      if (st_left > 0) begin
        st_left--;
        if (st_left == 0) dec_ready = rsave;
      end
      cyc++;
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    if (b < 128) tmo_cnt++;
  endtask

  task automatic test_reset();
    logic expv;
    #1 rst_n = 1'b0;
    st_valid = 1'b1; st_sop = 1'b1; st_data = 8'hA5; dec_ready = 2'b11;
    @(posedge clk); #1;
    checks++;
    if ({st_ready_out, dec_valid_out, dec_sop_out, dec_eop_out} !== 7'b0)
      begin errors++; $display("FAIL reset_handshake: got %b expected 0", {st_ready_out, dec_valid_out, dec_sop_out, dec_eop_out}); end
    checks++;
    if (dec_data_out !== 8'h00)
      begin errors++; $display("FAIL reset_data: got %h expected 00", dec_data_out); end
    checks++;
    if ({cur_core, err_len, err_credit} !== 7'b0)
      begin errors++; $display("FAIL reset_status: got %b expected 0", {cur_core, err_len, err_credit}); end
    st_data = 8'h00;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      expv = (c == 2);
      checks++;
      if (st_ready_out !== expv)
        begin errors++; $display("FAIL first_beat_latency c%0d: got %b expected %b", c, st_ready_out, expv); end
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    int exp_core[3] = '{0, 1, 0};
    int got;
    do_reset();
    dec_ready = 2'b11;
    tmo_cnt = 0;
    for (int f = 0; f < 3; f++) send_frame(127, -1, 0);
    checks++;
    if (frame_core.size() != 3 || tmo_cnt != 0)
      begin errors++; $display("FAIL b2b_count: got %0d frames (%0d timeouts) expected 3", frame_core.size(), tmo_cnt); end
    for (int f = 0; f < 3; f++) begin
      got = (frame_core.size() > f) ? frame_core[f] : -1;
      checks++;
      if (got != exp_core[f])
        begin errors++; $display("FAIL b2b_core f%0d: got %0d expected %0d", f, got, exp_core[f]); end
    end
    checks++;
    if (bad_sop != 0 || bad_eop != 0 || bad_data != 0 || bad_oh != 0)
      begin errors++; $display("FAIL b2b_framing: sop=%0d eop=%0d data=%0d onehot=%0d expected all 0", bad_sop, bad_eop, bad_data, bad_oh); end
    checks++;
    if (err_len !== 1'b0)
      begin errors++; $display("FAIL b2b_err_len: got %b expected 0", err_len); end
  endtask

  task automatic test_arb_ready();
    int held_bad = 0;
    int got;
    do_reset();
    dec_ready = 2'b10;
    tmo_cnt = 0;
    send_frame(127, -1, 0);
    got = (frame_core.size() > 0) ? frame_core[0] : -1;
    checks++;
    if (got != 1 || last_cur != 1 || tmo_cnt != 0)
      begin errors++; $display("FAIL arb_skip_core0: got core %0d cur_core %0d expected 1/1", got, last_cur); end
    dec_ready = 2'b00;
    st_valid = 1'b1; st_sop = 1'b1; st_data = 8'h00;
    repeat (6) begin
      @(negedge clk);
      if (st_ready_out !== 1'b0 || dec_valid_out !== 2'b00) held_bad++;
    end
    checks++;
    if (held_bad != 0)
      begin errors++; $display("FAIL arb_none_ready: got %0d active cycles expected 0", held_bad); end
    @(posedge clk); #1 dec_ready = 2'b11;
    send_frame(127, -1, 0);
    got = (frame_core.size() > 1) ? frame_core[1] : -1;
    checks++;
    if (got != 0 || last_cur != 0 || tmo_cnt != 0)
      begin errors++; $display("FAIL arb_ptr_wrap: got core %0d cur_core %0d expected 0/0", got, last_cur); end
  endtask

  task automatic test_credit_limit();
    int n0 = 0, n1 = 0, held_bad = 0, got;
    do_reset();
    dec_ready = 2'b11;
    tmo_cnt = 0;
    for (int f = 0; f < 8; f++) send_frame(127, -1, 0);
    foreach (frame_core[i]) begin
      if (frame_core[i] == 0) n0++;
      else n1++;
    end
    checks++;
    if (n0 != 4 || n1 != 4 || tmo_cnt != 0)
      begin errors++; $display("FAIL credit_split: got %0d/%0d expected 4/4", n0, n1); end
    st_valid = 1'b1; st_sop = 1'b1; st_data = 8'h00;
    repeat (10) begin
      @(negedge clk);
      if (st_ready_out !== 1'b0 || dec_valid_out !== 2'b00) held_bad++;
    end
    checks++;
    if (held_bad != 0)
      begin errors++; $display("FAIL credit_hold: got %0d active cycles expected 0", held_bad); end
    @(posedge clk); #1 dec_done = 2'b01;
    @(posedge clk); #1 dec_done = 2'b00;
    send_frame(127, -1, 0);
    got = (frame_core.size() > 8) ? frame_core[8] : -1;
    checks++;
    if (got != 0 || tmo_cnt != 0)
      begin errors++; $display("FAIL credit_release: got core %0d expected 0", got); end
    checks++;
    if (err_credit !== 2'b00)
      begin errors++; $display("FAIL credit_no_err: got %b expected 00", err_credit); end
  endtask

  task automatic test_stall();
    do_reset();
    dec_ready = 2'b11;
    tmo_cnt = 0; stall_cyc = 0; stall_bad = 0;
    send_frame(127, 60, 5);
    checks++;
    if (stall_cyc != 5 || stall_bad != 0)
      begin errors++; $display("FAIL stall_ready: got %0d cycles %0d not-low expected 5/0", stall_cyc, stall_bad); end
    checks++;
    if (frame_core.size() != 1 || tmo_cnt != 0 || bad_data != 0 || bad_eop != 0 || bad_sop != 0)
      begin errors++; $display("FAIL stall_frame: got %0d frames data=%0d eop=%0d expected 1/0/0", frame_core.size(), bad_data, bad_eop); end
  endtask

  task automatic test_len_err();
    do_reset();
    dec_ready = 2'b11;
    tmo_cnt = 0;
    checks++;
    if (err_len !== 1'b0)
      begin errors++; $display("FAIL len_err_init: got %b expected 0", err_len); end
    send_frame(100, -1, 0);
    checks++;
    if (err_len !== 1'b1)
      begin errors++; $display("FAIL len_err_set: got %b expected 1", err_len); end
    checks++;
    if (frame_core.size() != 1 || tmo_cnt != 0 || bad_eop != 0)
      begin errors++; $display("FAIL len_err_forward: got %0d frames eop_err=%0d expected 1/0", frame_core.size(), bad_eop); end
    send_frame(127, -1, 0);
    checks++;
    if (err_len !== 1'b1)
      begin errors++; $display("FAIL len_err_sticky: got %b expected 1", err_len); end
  endtask

  task automatic test_credit_err();
    int n1 = 0;
    do_reset();
    dec_ready = 2'b10;
    tmo_cnt = 0;
    @(posedge clk); #1 dec_done = 2'b10;
    @(posedge clk); #1 dec_done = 2'b00;
    checks++;
    if (err_credit !== 2'b10)
      begin errors++; $display("FAIL credit_err_set: got %b expected 10", err_credit); end
    for (int f = 0; f < 4; f++) send_frame(127, -1, 0);
    foreach (frame_core[i]) if (frame_core[i] == 1) n1++;
    checks++;
    if (n1 != 4 || tmo_cnt != 0)
      begin errors++; $display("FAIL credit_err_floor: got %0d frames on core1 (%0d timeouts) expected 4/0", n1, tmo_cnt); end
    checks++;
    if (err_credit !== 2'b10)
      begin errors++; $display("FAIL credit_err_sticky: got %b expected 10", err_credit); end
  endtask

  task automatic test_reset_midframe();
    int b = 0, cyc = 0, got;
    logic acc;
    do_reset();
    dec_ready = 2'b11;
    tmo_cnt = 0;
    send_frame(100, -1, 0);
    while (b < 20 && cyc < 200) begin
      st_valid = 1'b1; st_data = 8'(b); st_sop = (b == 0); st_eop = 1'b0;
      @(negedge clk);
      acc = st_ready_out;
      @(posedge clk); #1;
      if (acc) b++;
      cyc++;
    end
    if (b < 20) tmo_cnt++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({st_ready_out, dec_valid_out, dec_sop_out, dec_eop_out, dec_data_out} !== 15'b0)
      begin errors++; $display("FAIL midreset_outputs: got %b expected 0", {st_ready_out, dec_valid_out, dec_sop_out, dec_eop_out, dec_data_out}); end
    checks++;
    if ({cur_core, err_len, err_credit} !== 7'b0)
      begin errors++; $display("FAIL midreset_status: got %b expected 0", {cur_core, err_len, err_credit}); end
    st_valid = 1'b0; st_sop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(127, -1, 0);
    got = (frame_core.size() > 0) ? frame_core[frame_core.size() - 1] : -1;
    checks++;
    if (frame_core.size() != 2 || got != 0 || tmo_cnt != 0)
      begin errors++; $display("FAIL midreset_restart: got %0d frames last core %0d expected 2/0", frame_core.size(), got); end
    checks++;
    if (bad_sop != 0 || bad_eop != 0 || bad_data != 0 || bad_oh != 0)
      begin errors++; $display("FAIL final_framing: sop=%0d eop=%0d data=%0d onehot=%0d expected all 0", bad_sop, bad_eop, bad_data, bad_oh); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_arb_ready();
    test_credit_limit();
    test_stall();
    test_len_err();
    test_credit_err();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
